// File: rtl/line_window_buffer_if.sv
// Pixel-in / window-out bundle for line_window_buffer.
// Ports: pixelIn, pixelInValid and frameStart flow into the buffer; windowData, windowValid,
//   winX, winY, frameDone and overrun flow out. slave = buffer side, master = pixel source/sink.
interface line_window_buffer_if #(
  parameter int PIX_W = 4
);
  logic [PIX_W-1:0]   pixelIn;
  logic               pixelInValid;
  logic               frameStart;
  logic [9*PIX_W-1:0] windowData;
  logic               windowValid;
  logic [9:0]         winX;
  logic [8:0]         winY;
  logic               frameDone;
  logic               overrun;

  modport slave (
    input  pixelIn, pixelInValid, frameStart,
    output windowData, windowValid, winX, winY, frameDone, overrun
  );

  modport master (
    output pixelIn, pixelInValid, frameStart,
    input  windowData, windowValid, winX, winY, frameDone, overrun
  );
endinterface

// File: rtl/line_window_buffer.sv
// 3x3 sliding-window generator over a raster pixel stream, using two line memories.
// Ports: mainClk, nreset (async active-low), bus (slave side of line_window_buffer_if).
// Latency: window strobe 2 cycles after the completing pixel is accepted; no backpressure.
module line_window_buffer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 4
) (
  input  logic                  mainClk,
  input  logic                  nreset,
  line_window_buffer_if.slave   bus
);

  localparam int         AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [9:0] LAST_COL = 10'(IMG_WIDTH - 1);
  localparam logic [8:0] LAST_ROW = 9'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

  state_t     state_q, state_d, cur_state;
  logic [9:0] col_q, col_d, cur_col;
  logic [8:0] row_q, row_d, cur_row;
  logic       accept, emit, last;

  // frameStart overrides the current position so a pixel arriving with it is taken as (0,0).
  always_comb begin
    cur_state = bus.frameStart ? FILL : state_q;
    cur_col   = bus.frameStart ? 10'd0 : col_q;
    cur_row   = bus.frameStart ? 9'd0 : row_q;
    accept    = bus.pixelInValid && (cur_state == FILL || cur_state == STREAM);
    state_d   = cur_state;
    col_d     = cur_col;
    row_d     = cur_row;
    if (accept) begin
      if (cur_col == LAST_COL) begin
        col_d = 10'd0;
        if (cur_row == LAST_ROW) begin
          row_d   = 9'd0;
          state_d = DONE;
        end else begin
          row_d = cur_row + 9'd1;
          if (cur_state == FILL && cur_row == 9'd1) state_d = STREAM;
        end
      end else begin
        col_d = cur_col + 10'd1;
      end
    end
    emit = accept && (cur_state == STREAM) && (cur_col >= 10'd2);
    last = accept && (cur_col == LAST_COL) && (cur_row == LAST_ROW);
  end

  // Line memories: line_a holds line y-1, line_b holds y-2. Reads return the
  // pre-write contents, so each accept also shifts the column down one line.
  logic [PIX_W-1:0] line_a [IMG_WIDTH];
  logic [PIX_W-1:0] line_b [IMG_WIDTH];
  logic [PIX_W-1:0] rd_a, rd_b, s1_pix;
  logic [AW-1:0]    addr;

  assign addr = cur_col[AW-1:0];

  always_ff @(posedge mainClk) begin
    if (accept) begin
      line_b[addr] <= line_a[addr];
      line_a[addr] <= bus.pixelIn;
      rd_a         <= line_a[addr];
      rd_b         <= line_b[addr];
      s1_pix       <= bus.pixelIn;
    end
  end

  // Sliding column registers: tap[r][2] is the newest column, one shift per accepted pixel.
  logic [PIX_W-1:0]   tap [3][3];
  logic               s1_vld;
  logic [9*PIX_W-1:0] win_flat;

  always_ff @(posedge mainClk) begin
    if (s1_vld) begin
      for (int r = 0; r < 3; r++) begin
        tap[r][0] <= tap[r][1];
        tap[r][1] <= tap[r][2];
      end
      tap[0][2] <= rd_b;
      tap[1][2] <= rd_a;
      tap[2][2] <= s1_pix;
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win_flat[(r*3+c)*PIX_W +: PIX_W] = tap[r][c];
  end

  logic       s1_win, s1_last, s2_vld, s2_last;
  logic [9:0] s1_x, s2_x;
  logic [8:0] s1_y, s2_y;

  always_ff @(posedge mainClk or negedge nreset) begin
    if (!nreset) begin
      state_q         <= IDLE;
      col_q           <= '0;
      row_q           <= '0;
      s1_vld          <= 1'b0;
      s1_win          <= 1'b0;
      s1_last         <= 1'b0;
      s1_x            <= '0;
      s1_y            <= '0;
      s2_vld          <= 1'b0;
      s2_last         <= 1'b0;
      s2_x            <= '0;
      s2_y            <= '0;
      bus.windowValid <= 1'b0;
      bus.frameDone   <= 1'b0;
      bus.winX        <= '0;
      bus.winY        <= '0;
      bus.windowData  <= '0;
      bus.overrun     <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;

      s1_vld  <= accept;
      s1_win  <= emit;
      s1_last <= last;
      if (accept) begin
        s1_x <= cur_col - 10'd1;
        s1_y <= cur_row - 9'd1;
      end

      // A new frame squashes anything still travelling through stages 1 and 2.
      s2_vld <= !bus.frameStart && s1_vld && s1_win;
      if (s1_vld) begin
        s2_x    <= s1_x;
        s2_y    <= s1_y;
        s2_last <= s1_last;
      end

      bus.windowValid <= !bus.frameStart && s2_vld;
      bus.frameDone   <= !bus.frameStart && s2_vld && s2_last;
      if (!bus.frameStart && s2_vld) begin
        bus.winX       <= s2_x;
        bus.winY       <= s2_y;
        bus.windowData <= win_flat;
      end

      if (bus.frameStart)
        bus.overrun <= 1'b0;
      else if (bus.pixelInValid && state_q == DONE)
        bus.overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer on a 4x3 frame, pixel value (row*4+col) mod 16.
// Ports: drives the master side of line_window_buffer_if, mainClk and nreset.
// A negedge monitor collects every window strobe; checks compare against hand-derived values.
module tb_line_window_buffer;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PW = 4;

  logic mainClk = 1'b0;
  logic nreset  = 1'b0;
  always #5 mainClk = ~mainClk;

  line_window_buffer_if #(.PIX_W(PW)) bus ();

  line_window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
    .mainClk (mainClk),
    .nreset  (nreset),
    .bus     (bus)
  );

  typedef struct {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [35:0] d;
    logic        fd;
    int          cyc;
  } strobe_t;

  strobe_t sq[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fd_cnt   = 0;
  int acc[12];

  always @(posedge mainClk) cyc <= cyc + 1;

  always @(negedge mainClk) begin
    if (bus.windowValid)
      sq.push_back('{x: bus.winX, y: bus.winY, d: bus.windowData, fd: bus.frameDone, cyc: cyc});
    if (bus.frameDone) fd_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pv(input int r, input int c, input logic [3:0] m);
    return 4'((r * 4 + c) & 15) ^ m;
  endfunction

  function automatic logic [35:0] exp_win(input int x, input int y, input logic [3:0] m);
    logic [35:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*4 +: 4] = pv(y - 1 + r, x - 1 + c, m);
    return w;
  endfunction

  task automatic drive_px(input logic [3:0] v, input int gap, input logic fs, input int idx);
    @(negedge mainClk);
    bus.frameStart   = fs;
    bus.pixelInValid = 1'b1;
    bus.pixelIn      = v;
    if (idx >= 0 && idx < 12) acc[idx] = cyc + 1;
    if (gap > 0) begin
      @(negedge mainClk);
      bus.pixelInValid = 1'b0;
      bus.frameStart   = 1'b0;
      repeat (gap - 1) @(negedge mainClk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge mainClk);
    bus.pixelInValid = 1'b0;
    bus.frameStart   = 1'b0;
    repeat (n) @(negedge mainClk);
  endtask

  task automatic pulse_fs();
    @(negedge mainClk);
    bus.frameStart   = 1'b1;
    bus.pixelInValid = 1'b0;
    @(negedge mainClk);
    bus.frameStart   = 1'b0;
  endtask

  task automatic send_pixels(input int first, input int lst, input logic [3:0] m,
                             input int gap, input logic fs_first);
    for (int i = first; i <= lst; i++)
      drive_px(pv(i / 4, i % 4, m), gap, fs_first && (i == first), i);
  endtask

  task automatic check_frame(input string pfx);
    check({pfx, "_count"}, 64'(sq.size()), 64'd2);
    check({pfx, "_fd_count"}, 64'(fd_cnt), 64'd1);
    if (sq.size() >= 2) begin
      check({pfx, "_x0"}, 64'(sq[0].x), 64'd1);
      check({pfx, "_y0"}, 64'(sq[0].y), 64'd1);
      check({pfx, "_d0"}, 64'(sq[0].d), 64'(exp_win(1, 1, 4'h0)));
      check({pfx, "_lat0"}, 64'(sq[0].cyc - acc[10]), 64'd2);
      check({pfx, "_fd0"}, 64'(sq[0].fd), 64'd0);
      check({pfx, "_x1"}, 64'(sq[1].x), 64'd2);
      check({pfx, "_y1"}, 64'(sq[1].y), 64'd1);
      check({pfx, "_d1"}, 64'(sq[1].d), 64'(exp_win(2, 1, 4'h0)));
      check({pfx, "_lat1"}, 64'(sq[1].cyc - acc[11]), 64'd2);
      check({pfx, "_fd1"}, 64'(sq[1].fd), 64'd1);
    end
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_wv"},   64'(bus.windowValid), 64'd0);
    check({pfx, "_fd"},   64'(bus.frameDone),   64'd0);
    check({pfx, "_ovr"},  64'(bus.overrun),     64'd0);
    check({pfx, "_winx"}, 64'(bus.winX),        64'd0);
    check({pfx, "_winy"}, 64'(bus.winY),        64'd0);
    check({pfx, "_data"}, 64'(bus.windowData),  64'd0);
  endtask

  initial begin
    bus.pixelIn      = '0;
    bus.pixelInValid = 1'b0;
    bus.frameStart   = 1'b0;
    nreset           = 1'b0;
    repeat (3) @(negedge mainClk);
    check_outputs_zero("reset");
    nreset = 1'b1;

    // Pixels while IDLE must be ignored.
    sq.delete(); fd_cnt = 0;
    send_pixels(0, 11, 4'h0, 0, 1'b0);
    idle(4);
    check("idle_ignored", 64'(sq.size()), 64'd0);

    // Continuous frame.
    sq.delete(); fd_cnt = 0;
    pulse_fs();
    send_pixels(0, 11, 4'h0, 0, 1'b0);
    idle(6);
    check_frame("cont");

    // Extra pixel in DONE sets overrun, frameStart clears it.
    check("ovr_before", 64'(bus.overrun), 64'd0);
    drive_px(4'h7, 0, 1'b0, -1);
    idle(4);
    check("ovr_set", 64'(bus.overrun), 64'd1);
    check("ovr_no_strobe", 64'(sq.size()), 64'd2);
    pulse_fs();
    check("ovr_cleared", 64'(bus.overrun), 64'd0);

    // Same frame with 3 idle cycles between pixels.
    sq.delete(); fd_cnt = 0;
    pulse_fs();
    send_pixels(0, 11, 4'h0, 3, 1'b0);
    idle(6);
    check_frame("gap");

    // Aborted partial frame (inverted values) then a full frame.
    sq.delete(); fd_cnt = 0;
    pulse_fs();
    send_pixels(0, 6, 4'hF, 0, 1'b0);
    pulse_fs();
    send_pixels(0, 11, 4'h0, 0, 1'b0);
    idle(6);
    check_frame("restart");

    // Reset mid-frame after pixel 9.
    sq.delete(); fd_cnt = 0;
    pulse_fs();
    send_pixels(0, 9, 4'h0, 0, 1'b0);
    @(negedge mainClk);
    bus.pixelInValid = 1'b0;
    #2 nreset = 1'b0;
    #1 check_outputs_zero("mid_rst");
    @(negedge mainClk);
    nreset = 1'b1;
    send_pixels(10, 11, 4'h0, 0, 1'b0);
    idle(4);
    check("rst_no_strobe", 64'(sq.size()), 64'd0);
    check("rst_no_fd", 64'(fd_cnt), 64'd0);
    pulse_fs();
    send_pixels(0, 9, 4'h0, 0, 1'b0);
    idle(4);
    check("rst_10px", 64'(sq.size()), 64'd0);
    send_pixels(10, 10, 4'h0, 0, 1'b0);
    idle(4);
    check("rst_11px", 64'(sq.size()), 64'd1);
    if (sq.size() >= 1) check("rst_d0", 64'(sq[0].d), 64'(exp_win(1, 1, 4'h0)));
    send_pixels(11, 11, 4'h0, 0, 1'b0);
    idle(4);
    check("rst_total", 64'(sq.size()), 64'd2);
    check("rst_fd", 64'(fd_cnt), 64'd1);

    // frameStart together with the first pixel.
    sq.delete(); fd_cnt = 0;
    send_pixels(0, 11, 4'h0, 0, 1'b1);
    idle(6);
    check_frame("fs_px");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_window_buffer.md
LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 Parameters SHALL be: IMG_WIDTH, 640, pixels per line; IMG_HEIGHT, 480, lines per frame; PIX_W, 4, bits per pixel.
REQ-002 One clock, asynchronous active-low reset: mainClk in 1, rising-edge clock for all state (fed from oscClk domain); nreset in 1, asynchronous active-low reset.
REQ-003 pixelIn in PIX_W: raster-order pixel from SPI receive path.
REQ-004 pixelInValid in 1: pixelIn accepted on this mainClk edge; no backpressure.
REQ-005 frameStart in 1: single-cycle pulse marking start of new frame.
REQ-006 windowData out 9*PIX_W: 3x3 neighbourhood; tap (r,c) at bits [(r*3+c)*PIX_W +: PIX_W]; r=0 oldest line, c=0 leftmost column.
REQ-007 windowValid out 1: single-cycle strobe, windowData/winX/winY valid.
REQ-008 winX out 10: column of window centre pixel.
REQ-009 winY out 9: line of window centre pixel.
REQ-010 frameDone out 1: single-cycle pulse after last pixel of frame accepted.
REQ-011 overrun out 1: sticky flag, pixel received while in DONE.

Function
REQ-012 Two line memories of IMG_WIDTH x PIX_W SHALL hold lines y-1 and y-2; memory inference allowed, read latency absorbed internally.
REQ-013 Column counter col (0..IMG_WIDTH-1) and line counter row (0..IMG_HEIGHT-1) SHALL advance only on accepted pixels; col wraps to 0 and row increments at col==IMG_WIDTH-1.
REQ-014 State machine SHALL have states IDLE, FILL, STREAM, DONE.
REQ-015 IDLE: pixels ignored; frameStart -> FILL with col=row=0.
REQ-016 FILL: lines 0-1 written to line memories, no windows emitted; accepting last pixel of row 1 -> STREAM.
REQ-017 STREAM: each accepted pixel with col>=2 SHALL produce exactly one window, centre (col-1, row-1).
REQ-018 Window taps: row2 = current line cols col-2..col; row1 = line y-1 same cols; row0 = line y-2 same cols.
REQ-019 windowValid SHALL assert exactly 2 mainClk cycles after the accepting edge of the pixel completing the window; winX/winY/windowData stable in that cycle only.
REQ-020 Border centres (x=0, x=IMG_WIDTH-1, y=0, y=IMG_HEIGHT-1) SHALL produce no window; per frame exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) strobes.
REQ-021 Accepting pixel (IMG_WIDTH-1, IMG_HEIGHT-1) -> DONE; frameDone pulses in the same cycle as the final windowValid.
REQ-022 DONE: pixels ignored and set overrun; frameStart -> FILL.
REQ-023 frameStart in any state SHALL restart at FILL with col=row=0, discard pending windows still in the pipeline, and clear overrun.
REQ-024 frameStart and pixelInValid in same cycle: pixel SHALL be accepted as (0,0) of new frame.
REQ-025 Gaps in pixelInValid SHALL not alter window contents or strobe count; sliding column registers update only on accept.
REQ-026 No combinational path from inputs to outputs.

Reset
REQ-027 nreset low SHALL asynchronously force state IDLE, col=row=0, windowValid=0, frameDone=0, overrun=0, winX=0, winY=0, windowData=0; pipeline valid bits cleared.
REQ-028 Line-memory contents need not be reset; no window SHALL depend on memory contents written before the current frameStart.
REQ-029 Reset mid-frame: no windowValid or frameDone after release until a new frameStart and sufficient pixels.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3, pixel value = (row*4+col) mod 16)
REQ-030 Continuous frame of 12 pixels -> first strobe 2 cycles after pixel 10: winX=1, winY=1, taps row0={0,1,2}, row1={4,5,6}, row2={8,9,10}; second strobe winX=2, winY=1, taps {1,2,3},{5,6,7},{9,10,11}.
REQ-031 Same frame with 3-cycle idle gaps between pixels -> identical 2 windows; frameDone coincides with second strobe.
REQ-032 Extra pixel after frameDone -> overrun=1, no strobe; next frameStart -> overrun=0.
REQ-033 frameStart asserted after pixel 6 then full 12-pixel frame -> exactly 2 strobes, contents computed from new frame only.
REQ-034 nreset pulsed low after pixel 9 -> all outputs 0 immediately; no strobe until a new frameStart plus 11 pixels.
REQ-035 frameStart with pixelInValid same cycle, value 0 -> accepted as (0,0); frame completes with 2 strobes.
